// File: rtl/fetch_pkg.sv
`default_nettype none
// fetch_pkg: shared state encoding and constants for the instruction-fetch stage.
// Optional feature macro: FETCH_MISALIGN_EN (adds the S_FAULT state).
package fetch_pkg;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD  = 3'd4
`ifdef FETCH_MISALIGN_EN
    ,
    S_FAULT = 3'd5
`endif
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// fetch_buffer: one-entry {pc, instr} holding register; clear wins over load.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic            full_o
);

  logic            full_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (clear_i) begin
      full_q  <= 1'b0;
    end else if (load_i) begin
      full_q  <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign full_o  = full_q;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// if_stage: PC owner, single-outstanding imem fetch FSM with stall hold and redirect flush.
// Optional feature macro: FETCH_MISALIGN_EN (misaligned redirect -> S_FAULT, fault_o).
module if_stage
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o,
  output logic            fault_o
);

  localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_instr_q, out_instr_d;
  logic            out_valid_q, out_valid_d;

  logic            buf_load, buf_clear, buf_full;
  logic [XLEN-1:0] buf_pc, buf_instr;
  logic [XLEN-1:0] target;
  logic            still_out;

`ifdef FETCH_MISALIGN_EN
  logic fault_q, fault_d;
  logic fault_pend_q, fault_pend_d;
  logic misaligned;

  assign target     = redirect_pc_i;
  assign misaligned = |redirect_pc_i[1:0];
`else
  assign target     = redirect_pc_i & ALIGN_MASK;
`endif

  // A granted request whose response has not yet arrived (and will not arrive this cycle).
  always_comb begin
    still_out = 1'b0;
    unique case (state_q)
      S_REQ:           still_out = imem_gnt_i;
      S_WAIT, S_DRAIN: still_out = !imem_rvalid_i;
`ifdef FETCH_MISALIGN_EN
      S_FAULT:         still_out = fault_pend_q && !imem_rvalid_i;
`endif
      default:         still_out = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
`ifdef FETCH_MISALIGN_EN
    fault_d      = fault_q;
    fault_pend_d = fault_pend_q;
`endif
    if (redirect_i) begin
      out_valid_d = 1'b0;
      buf_clear   = 1'b1;
      pc_d        = target;
      state_d     = still_out ? S_DRAIN : S_REQ;
`ifdef FETCH_MISALIGN_EN
      fault_d      = misaligned;
      fault_pend_d = still_out;
      if (misaligned) state_d = S_FAULT;
`endif
    end else begin
      if (!stall_i) out_valid_d = 1'b0;
      unique case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_gnt_i) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + STEP;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (stall_i) begin
              buf_load = 1'b1;
              state_d  = S_HOLD;
            end else begin
              out_pc_d    = req_pc_q;
              out_instr_d = imem_rdata_i;
              out_valid_d = 1'b1;
              state_d     = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            out_pc_d    = buf_pc;
            out_instr_d = buf_instr;
            out_valid_d = buf_full;
            buf_clear   = 1'b1;
            state_d     = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid_i) state_d = S_REQ;
        end
`ifdef FETCH_MISALIGN_EN
        S_FAULT: begin
          if (imem_rvalid_i) fault_pend_d = 1'b0;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      fault_q      <= 1'b0;
      fault_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
`ifdef FETCH_MISALIGN_EN
      fault_q      <= fault_d;
      fault_pend_q <= fault_pend_d;
`endif
    end
  end

  fetch_buffer #(
    .XLEN(XLEN)
  ) u_fetch_buffer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .pc_i    (req_pc_q),
    .instr_i (imem_rdata_i),
    .pc_o    (buf_pc),
    .instr_o (buf_instr),
    .full_o  (buf_full)
  );

  assign imem_req_o  = (state_q == S_REQ);
  assign imem_addr_o = pc_q;
  assign pc_o        = out_pc_q;
  assign instr_o     = out_instr_q;
  assign valid_o     = out_valid_q;
`ifdef FETCH_MISALIGN_EN
  assign fault_o     = fault_q;
`else
  assign fault_o     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// tb_if_stage: directed + randomized checks of if_stage against a transaction-level fetch model.
// Honours FETCH_MISALIGN_EN in the same way as the design.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o, instr_o;
  logic        valid_o, fault_o;

  if_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .valid_o       (valid_o),
    .fault_o       (fault_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Memory responder state
  int          gnt_pct = 100;
  int          lat_min = 0;
  int          lat_max = 0;
  logic        m_pend  = 1'b0;
  int          m_lat   = 0;
  logic [31:0] m_addr  = '0;
  logic [31:0] granted[$];

  // Architectural fetch model
  logic [31:0] exp_pc    = '0;
  logic        exp_fault = 1'b0;
  logic [64:0] prev_out  = '0;
  int          delivered = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h1234_5678;
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    if (redirect_i) begin
      check("redirect_bubble", valid_o, 1'b0);
`ifdef FETCH_MISALIGN_EN
      exp_fault = (redirect_pc_i[1:0] != 2'b00);
      exp_pc    = redirect_pc_i;
`else
      exp_pc    = {redirect_pc_i[31:2], 2'b00};
`endif
    end else if (stall_i) begin
      check("stall_hold", {pc_o, instr_o, valid_o}, prev_out);
    end else if (valid_o) begin
      check("deliver_pc", pc_o, exp_pc);
      check("deliver_instr", instr_o, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    check("fault_o", fault_o, exp_fault);
    prev_out = {pc_o, instr_o, valid_o};
  endtask

  // One clock: present memory response/grant, advance, then check at the falling edge.
  task automatic tick();
    logic        gnt_now, rv_now;
    logic [31:0] a_now;
    rv_now        = m_pend && (m_lat == 0);
    gnt_now       = imem_req_o && !m_pend && ($urandom_range(99) < gnt_pct);
    imem_rvalid_i = rv_now;
    imem_rdata_i  = rv_now ? mem_word(m_addr) : $urandom();
    imem_gnt_i    = gnt_now;
    a_now         = imem_addr_o;
    if (imem_req_o) begin
      check("one_outstanding", m_pend, 1'b0);
      check("addr_aligned", a_now[1:0], 2'b00);
    end
    @(posedge clk);
    if (rv_now) m_pend = 1'b0;
    else if (m_pend && m_lat > 0) m_lat--;
    if (gnt_now) begin
      m_pend = 1'b1;
      m_addr = a_now;
      m_lat  = $urandom_range(lat_max, lat_min);
      granted.push_back(a_now);
    end
    @(negedge clk);
    model_check();
  endtask

  task automatic run_until_req(input int budget);
    int n;
    n = 0;
    while (!imem_req_o && n < budget) begin
      tick();
      n++;
    end
    check("req_timeout", imem_req_o, 1'b1);
  endtask

  task automatic run_until_valid(input int budget);
    int n;
    n = 0;
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    do begin
      tick();
      n++;
    end while (!valid_o && n < budget);
    check("valid_timeout", valid_o, 1'b1);
  endtask

  initial begin
    logic [31:0] rpc;
    int          rand_base;

    reset         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_outputs", {pc_o, instr_o, valid_o, fault_o}, '0);
    check("rst_req", imem_req_o, 1'b0);
    reset = 1'b1;
    check("idle_no_req", imem_req_o, 1'b0);

    // Zero-wait fetch
    tick();
    check("first_req", {imem_req_o, imem_addr_o}, {1'b1, 32'h0});
    tick();
    tick();
    check("zw_out", {pc_o, instr_o, valid_o}, {32'h0, 32'hDEAD_BEEF, 1'b1});
    tick();
    check("zw_bubble", valid_o, 1'b0);

    // Stall while the 0x4 response returns
    stall_i = 1'b1;
    tick();
    check("stall_keep_prior", {pc_o, instr_o}, {32'h0, 32'hDEAD_BEEF});
    check("hold_no_req_a", imem_req_o, 1'b0);
    tick();
    check("hold_no_req_b", imem_req_o, 1'b0);
    stall_i = 1'b0;
    tick();
    check("unstall_out", {pc_o, instr_o, valid_o}, {32'h4, 32'h1234_5678, 1'b1});

    // Redirect with an outstanding request
    lat_min = 2; lat_max = 2;
    tick();
    check("addr_seq", {granted[0], granted[1], granted[2]}, {32'h0, 32'h4, 32'h8});
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    check("drain_no_req_a", imem_req_o, 1'b0);
    tick();
    check("drain_no_req_b", imem_req_o, 1'b0);
    tick();
    check("redir_addr", {imem_req_o, imem_addr_o}, {1'b1, 32'h100});
    lat_min = 0; lat_max = 0;
    run_until_valid(20);
    check("redir_out", {pc_o, instr_o}, {32'h100, mem_word(32'h100)});

    // Redirect coincident with grant and stall
    run_until_req(20);
    lat_min = 1; lat_max = 1;
    redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h300;
    tick();
    redirect_i = 1'b0; stall_i = 1'b0;
    check("coinc_bubble", valid_o, 1'b0);
    check("coinc_drain", imem_req_o, 1'b0);
    run_until_req(20);
    check("coinc_target", imem_addr_o, 32'h300);

    // PC wrap
    lat_min = 0; lat_max = 0;
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    run_until_req(20);
    check("wrap_first", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    run_until_req(20);
    check("wrap_addr", imem_addr_o, 32'h0);

    // Misaligned redirect
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    tick();
    redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_EN
    check("mis_fault", fault_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mis_no_req", imem_req_o, 1'b0);
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    tick();
    redirect_i = 1'b0;
    check("mis_clear", fault_o, 1'b0);
    run_until_req(20);
    check("mis_resume", imem_addr_o, 32'h200);
`else
    run_until_req(20);
    check("mis_forced", imem_addr_o, 32'h100);
    check("mis_no_fault", fault_o, 1'b0);
`endif

    // Randomized traffic against the model
    gnt_pct = 60; lat_min = 0; lat_max = 3;
    rand_base = delivered;
    for (int i = 0; i < 500; i++) begin
      stall_i    = ($urandom_range(3) == 0);
      redirect_i = ($urandom_range(19) == 0);
      rpc        = $urandom();
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      redirect_pc_i = rpc;
      tick();
    end
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    check("rand_progress", (delivered - rand_base) >= 15, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage, directly upstream of the IF/ID pipeline register. It owns the program counter and issues one word-aligned request at a time to instruction memory over a request/grant/response handshake. It presents `{pc_o, instr_o, valid_o}` to IF/ID, honours hazard-unit stalls, and flushes on branch/jump redirects from execute.

## Interface
- `XLEN`, default 32: address and instruction width.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `stall_i`  in  1  IF/ID stalled; hold the current output.
- `redirect_i`  in  1  flush and refetch from `redirect_pc_i`.
- `redirect_pc_i`  in  XLEN  redirect target.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  XLEN  fetch address, equal to the current PC.
- `imem_gnt_i`  in  1  request accepted this cycle.
- `imem_rvalid_i`  in  1  response data valid.
- `imem_rdata_i`  in  XLEN  fetched instruction.
- `pc_o`  out  XLEN  address of `instr_o`.
- `instr_o`  out  XLEN  instruction to IF/ID.
- `valid_o`  out  1  output holds a real instruction (0 = bubble).
- `fault_o`  out  1  misaligned redirect detected; tied 0 when the feature is compiled out.

## Operation
- **States:** S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_HOLD, plus S_FAULT when `FETCH_MISALIGN_EN` is defined.
- **Reset values:**
  - state = S_IDLE; PC = RESET_PC.
  - `pc_o` = 0, `instr_o` = 0, `valid_o` = 0, `fault_o` = 0.
  - Buffer empty; `imem_req_o` = 0.
- **S_IDLE:** go to S_REQ unconditionally.
- **S_REQ:**
  - `imem_req_o` = 1 and `imem_addr_o` = PC.
  - On `imem_gnt_i`: PC ← PC+4, go to S_WAIT.
- **S_WAIT:** on `imem_rvalid_i`:
  - If `stall_i` = 0: load the output registers (`pc_o` = address of the granted request), set `valid_o` = 1, go to S_REQ.
  - If `stall_i` = 1: capture the response into the one-entry buffer, go to S_HOLD.
- **S_HOLD:** when `stall_i` = 0, move the buffer to the output registers, go to S_REQ.
- **Output registers:**
  - Hold while `stall_i` = 1.
  - In any cycle with `stall_i` = 0 and no data to load, `valid_o` ← 0 (bubble).
  - `pc_o`/`instr_o` keep their stale values when `valid_o` = 0.
- **Redirect (highest priority, overrides stall):**
  - Next cycle: `valid_o` = 0, buffer cleared, PC ← `redirect_pc_i`.
  - From S_REQ without grant, S_HOLD or S_IDLE: go to S_REQ. Abandoning an ungranted request is legal.
  - From S_REQ with `imem_gnt_i` in the same cycle, or from S_WAIT without `imem_rvalid_i`: go to S_DRAIN.
  - From S_WAIT with `imem_rvalid_i` in the same cycle: drop the response, go to S_REQ.
- **S_DRAIN:** `imem_req_o` = 0; on `imem_rvalid_i`, discard the data and go to S_REQ. A redirect in S_DRAIN updates PC and stays in S_DRAIN.
- **PC arithmetic:** XLEN-bit, wraps modulo 2^XLEN (0xFFFF_FFFC + 4 → 0).
- **Outstanding requests:** at most one at any time.

## Timing
- Memory contract: `imem_rvalid_i` never arrives in the grant cycle.
- Request sequence: request visible in cycle N; grant in N gives `rvalid` at N+1 or later.
- Output latency: `valid_o` rises on the clock edge ending the `rvalid` cycle. Zero-wait memory gives one instruction every 2 cycles.
- Redirect latency: redirect in cycle R → `valid_o` = 0 in R+1; new request in R+1 (not draining); first redirected instruction valid in R+3 at the earliest.
- Reset: assertion clears state immediately. First request appears in cycle 2 after the deasserting edge.

## Configuration
- `FETCH_MISALIGN_EN` defined: a redirect with `redirect_pc_i[1:0]` ≠ 0 does the following.
  - Enter S_FAULT, set `fault_o` = 1, set `valid_o` = 0.
  - No requests are issued while in S_FAULT.
  - An aligned redirect clears `fault_o` and resumes via S_REQ (or via S_DRAIN if a response is outstanding).
- Macro not defined: `redirect_pc_i[1:0]` is forced to 0, `fault_o` is tied to 0, and S_FAULT does not exist.

## Structure
- Package `fetch_pkg`:
  - state enum `fetch_state_e`.
  - `INSTR_BYTES` = 4.
  - default `RESET_PC`.
- Sub-module `fetch_buffer`: one-entry `{pc, instr}` holding register with load/clear/full. Instantiated once.

## Test plan
- **Reset and zero-wait fetch:** release reset with `gnt` always 1 and `rvalid` one cycle after grant, `rdata` = 0xDEADBEEF → `imem_addr_o` sequence 0x0, 0x4, 0x8; `pc_o`=0x0 `instr_o`=0xDEADBEEF `valid_o`=1, valid every second cycle.
- **Stall during response:** `stall_i`=1 while `rdata` 0x12345678 returns for address 0x4 → outputs keep the prior instruction; after stall drops, `pc_o`=0x4 `instr_o`=0x12345678 one cycle later; no request issued in S_HOLD.
- **Redirect with outstanding request:** grant at address 0x8, then redirect to 0x100 before `rvalid` → the 0x8 response is never seen on `valid_o`; next `imem_addr_o` = 0x100.
- **Redirect coincident with grant and with stall:** `redirect_i`, `imem_gnt_i` and `stall_i` all high in one cycle → `valid_o`=0 next cycle, FSM in S_DRAIN, then a request to the target.
- **PC wrap:** redirect to 0xFFFF_FFFC → the following request address is 0x0000_0000.
- **Misalignment (`FETCH_MISALIGN_EN`):** redirect to 0x102 → `fault_o`=1, `imem_req_o`=0; redirect to 0x200 → `fault_o`=0 and a request to 0x200. With the macro undefined, redirect to 0x102 fetches 0x100.
